// File: rtl/register_file_mp.sv
// Multi-read-port register file with a write-to-read bypass, a pending scoreboard for
// hazard detection, and a clear engine that zeroes one entry per cycle.
module register_file_mp #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD*REG_WIDTH-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]            rd_pending_o,
    input  logic                         wr_ena_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [REG_WIDTH-1:0]         wr_data_i,
    input  logic                         resv_ena_i,
    input  logic [ADDR_WIDTH-1:0]        resv_addr_i,
    input  logic                         clr_req_i,
    output logic                         clr_busy_o
);

    localparam int unsigned           DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CntLast = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [REG_WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic idle;
    logic wr_zero;
    logic resv_zero;
    logic wr_en;

    assign idle      = (state_q == StIdle);
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr_i == '0);
    assign resv_zero = (ZERO_REG != 0) && (resv_addr_i == '0);
    // Writes only land while idle; the clear engine owns the array otherwise.
    assign wr_en     = idle & wr_ena_i & ~wr_zero;

    // State register, clear counter and scoreboard.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (clr_req_i) state_d = StClear;
            StClear: if (cnt_q == CntLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Clear counter: restarts on entry to clear, saturates at the last entry.
    always_comb begin
        cnt_d = cnt_q;
        if (idle && clr_req_i) begin
            cnt_d = '0;
        end else if (state_q == StClear && cnt_q != CntLast) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Scoreboard: writeback releases, issue reserves; a reserve to the same entry wins.
    always_comb begin
        pending_d = pending_q;
        if (idle) begin
            if (clr_req_i) begin
                pending_d = '0;
            end else begin
                if (wr_ena_i) pending_d[wr_addr_i] = 1'b0;
                if (resv_ena_i && !resv_zero) pending_d[resv_addr_i] = 1'b1;
            end
        end
    end

    // Storage array: normal writes while idle, one entry zeroed per cycle while clearing.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end else if (state_q == StClear) begin
            mem_q[cnt_q] <= '0;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        clr_busy_o = (state_q == StClear);
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  zero_hit;
        logic                  byp_hit;

        assign addr     = rd_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign zero_hit = (ZERO_REG != 0) && (addr == '0);
        // Bypass is suppressed during clear, since the write would be dropped.
        assign byp_hit  = (BYPASS != 0) && idle && wr_ena_i && (wr_addr_i == addr) && !zero_hit;

        assign rd_data_o[g*REG_WIDTH +: REG_WIDTH] = zero_hit ? '0 :
                                                     byp_hit  ? wr_data_i : mem_q[addr];
        assign rd_pending_o[g] = pending_q[addr] & ~byp_hit & ~zero_hit;
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one instance with bypass, one without, sharing inputs.
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_pending, rd_pending_nb;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        resv_ena;
    logic [4:0]  resv_addr;
    logic        clr_req;
    logic        clr_busy, clr_busy_nb;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    register_file_mp #(.BYPASS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_pending_o(rd_pending), .wr_ena_i(wr_ena), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .resv_ena_i(resv_ena), .resv_addr_i(resv_addr), .clr_req_i(clr_req),
        .clr_busy_o(clr_busy)
    );

    register_file_mp #(.BYPASS(0)) dut_nb (
        .clk_i(clk), .rst_ni(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb),
        .rd_pending_o(rd_pending_nb), .wr_ena_i(wr_ena), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .resv_ena_i(resv_ena), .resv_addr_i(resv_addr),
        .clr_req_i(clr_req), .clr_busy_o(clr_busy_nb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        resv_ena = 1'b0; resv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_ena = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_ena = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        set_rd(0, 0);
        #12;
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            #1;
            vectors++;
            if (rd_data !== 64'h0 || rd_pending !== 2'b00 || clr_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset addr %0d: data=%h pend=%b busy=%b expected 0/00/0",
                         a, rd_data, rd_pending, clr_busy);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_bypass();
        set_rd(5, 0);
        wr_ena = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[31:0]);
        end
        vectors++;
        if (rd_data_nb[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL nobypass_same_cycle: got %h expected 00000000", rd_data_nb[31:0]);
        end
        tick();
        wr_ena = 1'b0;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_data_nb[31:0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL write_next_cycle: got %h/%h expected deadbeef/deadbeef",
                     rd_data[31:0], rd_data_nb[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        set_rd(0, 5);
        wr_ena = 1'b1; wr_addr = 0; wr_data = 32'h1234;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_bypass: got %h expected 00000000", rd_data[31:0]);
        end
        tick();
        wr_ena = 1'b0;
        resv_ena = 1'b1; resv_addr = 0;
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL zero_write: got r0=%h r5=%h expected 00000000/deadbeef",
                     rd_data[31:0], rd_data[63:32]);
        end
        tick();
        resv_ena = 1'b0;
        #1;
        vectors++;
        if (rd_pending[0] !== 1'b0 || rd_pending_nb[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pending: got %b/%b expected 0/0", rd_pending[0], rd_pending_nb[0]);
        end
    endtask

    task automatic test_pending();
        set_rd(0, 7);
        resv_ena = 1'b1; resv_addr = 7;
        tick();
        resv_ena = 1'b0;
        #1;
        vectors++;
        if (rd_pending[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL reserve: got %b expected 1", rd_pending[1]);
        end
        // Writeback in flight: bypass instance hides the hazard, plain instance still shows it.
        wr_ena = 1'b1; wr_addr = 7; wr_data = 32'h77;
        resv_ena = 1'b1; resv_addr = 7;
        #1;
        vectors++;
        if (rd_pending[1] !== 1'b0 || rd_pending_nb[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL pending_bypass: got %b/%b expected 0/1", rd_pending[1], rd_pending_nb[1]);
        end
        tick();
        wr_ena = 1'b0; resv_ena = 1'b0;
        #1;
        vectors++;
        if (rd_pending[1] !== 1'b1 || rd_data[63:32] !== 32'h77) begin
            miscompares++;
            $display("FAIL set_wins: got pend=%b data=%h expected 1/00000077",
                     rd_pending[1], rd_data[63:32]);
        end
        write_reg(7, 32'h78);
        #1;
        vectors++;
        if (rd_pending[1] !== 1'b0 || rd_pending_nb[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL release: got %b/%b expected 0/0", rd_pending[1], rd_pending_nb[1]);
        end
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i + 1));
        set_rd(0, 31);
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'd32) begin
            miscompares++;
            $display("FAIL fill: got r0=%h r31=%h expected 00000000/00000020",
                     rd_data[31:0], rd_data[63:32]);
        end
        resv_ena = 1'b1; resv_addr = 12;
        tick();
        // Clear request with a write and a reservation in the same cycle.
        clr_req = 1'b1;
        wr_ena = 1'b1; wr_addr = 9; wr_data = 32'hAAAA;
        resv_ena = 1'b1; resv_addr = 3;
        set_rd(12, 3);
        tick();
        idle_inputs();
        #1;
        vectors++;
        if (clr_busy !== 1'b1 || rd_pending !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_start: got busy=%b pend=%b expected 1/00", clr_busy, rd_pending);
        end
        busy_cycles = 0;
        while (clr_busy && busy_cycles < 40) begin
            busy_cycles++;
            if (busy_cycles == 6) begin
                set_rd(4, 10);
                wr_ena = 1'b1; wr_addr = 10; wr_data = 32'hBAD;
                #1;
                vectors++;
                if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'd11) begin
                    miscompares++;
                    $display("FAIL mid_clear: got r4=%h r10=%h expected 00000000/0000000b",
                             rd_data[31:0], rd_data[63:32]);
                end
            end
            if (busy_cycles == 10) clr_req = 1'b1;
            tick();
            idle_inputs();
        end
        vectors++;
        if (busy_cycles !== 32) begin
            miscompares++;
            $display("FAIL clear_length: got %0d cycles expected 32", busy_cycles);
        end
        for (int a = 0; a < 32; a += 2) begin
            set_rd(5'(a), 5'(a + 1));
            #1;
            vectors++;
            if (rd_data !== 64'h0 || clr_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL after_clear addr %0d: got %h busy=%b expected 0/0",
                         a, rd_data, clr_busy);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        write_reg(20, 32'h22);
        write_reg(25, 32'h25);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        set_rd(20, 25);
        #1;
        vectors++;
        if (clr_busy !== 1'b1 || rd_data[31:0] !== 32'h22) begin
            miscompares++;
            $display("FAIL pre_reset: got busy=%b r20=%h expected 1/00000022",
                     clr_busy, rd_data[31:0]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (clr_busy !== 1'b0 || rd_data !== 64'h0) begin
            miscompares++;
            $display("FAIL mid_clear_reset: got busy=%b data=%h expected 0/0", clr_busy, rd_data);
        end
        #2;
        rst_n = 1'b1;
        tick();
        set_rd(6, 25);
        write_reg(6, 32'h66);
        #1;
        vectors++;
        if (rd_data[31:0] !== 32'h66 || rd_data[63:32] !== 32'h0 || clr_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: got r6=%h r25=%h busy=%b expected 00000066/0/0",
                     rd_data[31:0], rd_data[63:32], clr_busy);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_pending();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
